// File: rtl/state_dump_unit_pkg.sv
// Shared types and constants for the state dump unit: FSM encoding, word tags, output word layout.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package state_dump_unit_pkg;

    // Width of the register/memory word index counter
    localparam int IDX_W = 8;

    // out_is_mem tag values
    localparam logic DUMP_TAG_REG = 1'b0;
    localparam logic DUMP_TAG_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_RF_RD   = 3'd2,
        ST_RF_OUT  = 3'd3,
        ST_DM_RD   = 3'd4,
        ST_DM_WAIT = 3'd5,
        ST_DM_OUT  = 3'd6,
        ST_FIN     = 3'd7
    } state_t;

    // One dumped word together with its sideband
    typedef struct packed {
        logic [31:0]      data;
        logic             is_mem;
        logic [IDX_W-1:0] index;
        logic             last;
    } out_word_t;

    // True when idx addresses the final entry of a phase holding count entries
    function automatic logic is_final(input logic [IDX_W-1:0] idx, input int count);
        return int'(idx) == (count - 1);
    endfunction

endpackage

// File: rtl/state_dump_unit_if.sv
// Valid/ready stream carrying dumped words from the dump unit to its sink.
// Latency: n/a (wiring only).
// Backpressure: sink holds out_ready low to stall; master keeps the word stable meanwhile.
interface state_dump_unit_if;
    import state_dump_unit_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_is_mem;
    logic [IDX_W-1:0] out_index;
    logic             out_last;

    modport master (
        output out_valid, out_data, out_is_mem, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_is_mem, out_index, out_last,
        output out_ready
    );

endinterface

// File: rtl/dump_out_reg.sv
// Holding stage for the dump output stream: captures a word on load and presents it until accepted.
// Latency: word visible on out_* the cycle after load.
// Backpressure: word and valid held unchanged while out_ready is low; valid clears on handshake.
module dump_out_reg
    import state_dump_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  out_word_t load_word,
    state_dump_unit_if.master out_if
);

    out_word_t word_q, word_d;
    logic      valid_q, valid_d;

    // Next holding-register contents: a handshake empties it, a load refills it
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            word_d  = load_word;
            valid_d = 1'b1;
        end
    end

    // Holding register, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign out_if.out_valid  = valid_q;
    assign out_if.out_data   = word_q.data;
    assign out_if.out_is_mem = word_q.is_mem;
    assign out_if.out_index  = word_q.index;
    assign out_if.out_last   = word_q.last;

endmodule

// File: rtl/state_dump_unit.sv
// Halts the core, then streams x0..x(NUM_REGS-1) followed by MEM_BYTES of data memory.
// Latency: first word 2 cycles after halt_ack; 2 cycles per register, 3 per memory word at full rate.
// Backpressure: each word waits in the output stage until out_ready; the FSM does not advance meanwhile.
module state_dump_unit
    import state_dump_unit_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int MEM_BASE  = 0,
    parameter int MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        halt_req,
    input  logic        halt_ack,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        dm_rd_en,
    output logic [31:0] dm_rd_addr,
    input  logic [31:0] dm_rd_data,
    state_dump_unit_if.master out_if
);

    localparam int          MEM_WORDS  = MEM_BYTES / 4;
    localparam logic [31:0] MEM_BASE_W = 32'(MEM_BASE);

    // Parameter sanity: the 8-bit index must cover every memory word
    if (NUM_REGS < 1 || NUM_REGS > 32) begin : g_bad_num_regs
        $error("state_dump_unit: NUM_REGS must be in 1..32");
    end
    if ((MEM_BYTES % 4) != 0 || (MEM_BASE % 4) != 0) begin : g_bad_align
        $error("state_dump_unit: MEM_BASE and MEM_BYTES must be multiples of 4");
    end
    if (MEM_WORDS > 256) begin : g_bad_mem_bytes
        $error("state_dump_unit: MEM_BYTES/4 must not exceed 256");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             load;
    out_word_t        load_word;
    logic             out_hs;

    assign out_hs = out_if.out_valid & out_if.out_ready;

    // Next state, index and per-state outputs
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        load       = 1'b0;
        load_word  = '0;
        rf_rd_addr = '0;
        dm_rd_en   = 1'b0;
        dm_rd_addr = '0;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_FIN);
        halt_req   = (state_q != ST_IDLE) && (state_q != ST_FIN);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (halt_ack) begin
                    state_d = ST_RF_RD;
                end
            end
            ST_RF_RD: begin
                // Register file reads combinationally: capture this cycle
                rf_rd_addr       = idx_q[4:0];
                load             = 1'b1;
                load_word.data   = rf_rd_data;
                load_word.is_mem = DUMP_TAG_REG;
                load_word.index  = idx_q;
                load_word.last   = (MEM_WORDS == 0) && is_final(idx_q, NUM_REGS);
                state_d          = ST_RF_OUT;
            end
            ST_RF_OUT: begin
                if (out_hs) begin
                    if (!is_final(idx_q, NUM_REGS)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RF_RD;
                    end else begin
                        idx_d   = '0;
                        state_d = (MEM_WORDS == 0) ? ST_FIN : ST_DM_RD;
                    end
                end
            end
            ST_DM_RD: begin
                dm_rd_en   = 1'b1;
                dm_rd_addr = MEM_BASE_W + {{(32-IDX_W-2){1'b0}}, idx_q, 2'b00};
                state_d    = ST_DM_WAIT;
            end
            ST_DM_WAIT: begin
                // Memory data returns one cycle after the read strobe
                load             = 1'b1;
                load_word.data   = dm_rd_data;
                load_word.is_mem = DUMP_TAG_MEM;
                load_word.index  = idx_q;
                load_word.last   = is_final(idx_q, MEM_WORDS);
                state_d          = ST_DM_OUT;
            end
            ST_DM_OUT: begin
                if (out_hs) begin
                    if (!is_final(idx_q, MEM_WORDS)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DM_RD;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and index registers; reset aborts any dump in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    dump_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_word (load_word),
        .out_if    (out_if)
    );

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: directed sequence with randomized data and out_ready, checked against a word-list model.
// Latency: n/a.
// Backpressure: out_ready randomized in several runs.
module tb_state_dump_unit;
    import state_dump_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT A: 32 registers + 32 memory bytes
    logic        start, busy, done, halt_req, halt_ack, out_ready;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        dm_rd_en;
    logic [31:0] dm_rd_addr, dm_rd_data;
    state_dump_unit_if sif();
    assign sif.out_ready = out_ready;

    // DUT B: 4 registers, no memory phase
    logic        start_b, busy_b, done_b, halt_req_b, halt_ack_b, out_ready_b;
    logic [4:0]  rf_rd_addr_b;
    logic [31:0] rf_rd_data_b;
    logic        dm_rd_en_b;
    logic [31:0] dm_rd_addr_b, dm_rd_data_b;
    state_dump_unit_if sif_b();
    assign sif_b.out_ready = out_ready_b;

    // Core-side models: register file and little-endian byte memory
    logic [31:0] regs [32];
    logic [7:0]  mem  [256];

    assign rf_rd_data   = regs[rf_rd_addr];
    assign rf_rd_data_b = regs[rf_rd_addr_b];
    assign dm_rd_data_b = 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (dm_rd_en) begin
            dm_rd_data <= {mem[dm_rd_addr[7:0] + 8'd3], mem[dm_rd_addr[7:0] + 8'd2],
                           mem[dm_rd_addr[7:0] + 8'd1], mem[dm_rd_addr[7:0]]};
        end
    end

    state_dump_unit #(.NUM_REGS(32), .MEM_BASE(0), .MEM_BYTES(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .dm_rd_en(dm_rd_en), .dm_rd_addr(dm_rd_addr), .dm_rd_data(dm_rd_data),
        .out_if(sif)
    );

    state_dump_unit #(.NUM_REGS(4), .MEM_BASE(0), .MEM_BYTES(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .halt_req(halt_req_b), .halt_ack(halt_ack_b),
        .rf_rd_addr(rf_rd_addr_b), .rf_rd_data(rf_rd_data_b),
        .dm_rd_en(dm_rd_en_b), .dm_rd_addr(dm_rd_addr_b), .dm_rd_data(dm_rd_data_b),
        .out_if(sif_b)
    );

    int        n_checks = 0;
    int        n_fail   = 0;
    out_word_t exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected dump: every register in order, then each memory word assembled from bytes
    task automatic build_expected(input int nregs, input int mbytes);
        out_word_t w;
        exp_q.delete();
        for (int i = 0; i < nregs; i++) begin
            w.data = regs[i]; w.is_mem = 1'b0; w.index = 8'(i);
            w.last = (mbytes == 0) && (i == nregs - 1);
            exp_q.push_back(w);
        end
        for (int k = 0; k < mbytes / 4; k++) begin
            w.data = {mem[4*k+3], mem[4*k+2], mem[4*k+1], mem[4*k]};
            w.is_mem = 1'b1; w.index = 8'(k);
            w.last = (k == mbytes / 4 - 1);
            exp_q.push_back(w);
        end
    endtask

    // One dump on DUT A; optional random backpressure, timing checks, spurious starts, mid-dump reset
    task automatic run_a(input int ack_delay, input bit rand_ready, input bit timing_chk,
                         input bit abort_en, input bit extra_starts);
        int        halt_cnt = 0, ack_cyc = -1, first_valid = -1, last_acc = -1;
        int        n_acc = 0, dm_issued = 0, done_seen = 0;
        bit        stalled = 0, finished = 0;
        out_word_t cur, held, e;
        held = '0;
        build_expected(32, 32);
        @(posedge clk); #1; start = 1'b1; out_ready = 1'b0; halt_ack = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            cur = '{data: sif.out_data, is_mem: sif.out_is_mem, index: sif.out_index, last: sif.out_last};
            if (cyc == 0) check("busy_after_start", busy, 1);
            if (halt_req) halt_cnt++;
            if (halt_ack && ack_cyc < 0) ack_cyc = cyc;
            if (sif.out_valid && first_valid < 0) begin
                first_valid = cyc;
                if (timing_chk) check("first_valid_latency", cyc, ack_cyc + 2);
            end
            if (stalled) check("stall_stable", {sif.out_valid, cur}, {1'b1, held});
            if (dm_rd_en) begin
                check("dm_rd_addr", dm_rd_addr, 32'(4 * dm_issued));
                dm_issued++;
            end
            if (abort_en && sif.out_valid && sif.out_is_mem && sif.out_index == 8'd2) begin
                rst = 1'b0;
                #1;
                check("abort_halt_req", halt_req, 0);
                check("abort_out_valid", sif.out_valid, 0);
                check("abort_busy", busy, 0);
                @(posedge clk); #1;
                check("abort_no_done", done, 0);
                @(negedge clk);
                rst = 1'b1; start = 1'b0; halt_ack = 1'b0; out_ready = 1'b0;
                return;
            end
            if (done) begin
                done_seen++;
                check("done_timing", cyc, last_acc + 1);
                check("done_all_words", exp_q.size(), 0);
                finished = 1'b1;
            end
            if (sif.out_valid && out_ready) begin
                check("word_available", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("word", cur, e);
                end
                if (timing_chk && n_acc > 0) check("word_spacing", cyc - last_acc, cur.is_mem ? 3 : 2);
                last_acc = cyc;
                n_acc++;
                stalled = 1'b0;
            end else begin
                stalled = sif.out_valid;
            end
            held = cur;
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            halt_ack  = (halt_cnt >= ack_delay) && (!rand_ready || n_acc < 3) && !finished;
            start     = extra_starts && !finished &&
                        ((cyc == 20) || (exp_q.size() == 0 && last_acc == cyc));
        end
        start = 1'b0; halt_ack = 1'b0;
        check("dump_completed", finished, 1);
        check("done_count", done_seen, 1);
        check("words_accepted", n_acc, 40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_halt_req", halt_req, 0);
            check("idle_out_valid", sif.out_valid, 0);
            check("idle_done", done, 0);
        end
    endtask

    // One dump on DUT B (registers only)
    task automatic run_b();
        int        n = 0, dm_cnt = 0;
        bit        fin = 0;
        out_word_t cur, e;
        build_expected(4, 0);
        @(posedge clk); #1; start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
            @(negedge clk);
            cur = '{data: sif_b.out_data, is_mem: sif_b.out_is_mem, index: sif_b.out_index, last: sif_b.out_last};
            if (dm_rd_en_b) dm_cnt++;
            if (done_b) fin = 1'b1;
            if (sif_b.out_valid && out_ready_b) begin
                check("b_word_available", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b_word", cur, e);
                end
                n++;
            end
            @(posedge clk); #1;
            halt_ack_b  = halt_req_b;
            out_ready_b = 1'($urandom_range(0, 1));
        end
        check("b_finished", fin, 1);
        check("b_words", n, 4);
        check("b_no_dm_rd", dm_cnt, 0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0; halt_ack = 1'b0; out_ready = 1'b0;
        start_b = 1'b0; halt_ack_b = 1'b0; out_ready_b = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_halt_req", halt_req, 0);
        check("rst_out_valid", sif.out_valid, 0);
        check("rst_out_data", sif.out_data, 0);
        check("rst_out_last", sif.out_last, 0);
        check("rst_dm_rd_en", dm_rd_en, 0);
        check("rst_dm_rd_addr", dm_rd_addr, 0);
        check("rst_rf_rd_addr", rf_rd_addr, 0);
        check("rst_b_out_valid", sif_b.out_valid, 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed contents, full-rate sink, latency checks
        run_a(3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random contents with a stalling sink and spurious starts
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        run_a(5, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset during memory word 2, then a complete dump
        run_a(2, 1'b0, 1'b0, 1'b1, 1'b0);
        run_a(4, 1'b1, 1'b0, 1'b0, 1'b0);

        // Register-only configuration
        run_b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
